// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_seq_pkg;

  localparam int unsigned AR_W   = 16;
  localparam int unsigned NB_W   = 4;
  localparam int unsigned ADDR_W = NB_W + AR_W;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  // Cycles spent in REQ before the no-answer alarm fires.
  localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 8'd100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_timeout.sv
// Bus-answer watchdog: counts cycles spent waiting in REQ.
module mem_timeout
  import mem_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_sys,
  input  logic clr_,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [CNT_W-1:0] count_q;

  // Clear wins over enable so a fresh access always starts from zero.
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Fires on the last REQ cycle the sequencer is allowed to wait.
  assign expired_c = (count_q == (TIMEOUT - CNT_W'(1)));

endmodule

// File: rtl/mem_seq.sv
// Memory access sequencer: drives one four-phase bus access per start pulse.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              clr_,
  input  logic [AR_W-1:0]   ar,
  input  logic [DATA_W-1:0] at,
  input  logic [NB_W-1:0]   nb,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic              inc,
  input  logic              ok,
  input  logic              en,
  input  logic              pe,
  input  logic [DATA_W-1:0] d_in,
  output logic              req,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d_out,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ar_p1,
  output logic              alarm_nomem,
  output logic              alarm_parity
);

  state_e            state_q, state_d;
  logic              dir_rd_q, dir_rd_d;
  logic              inc_q, inc_d;
  logic              ok_hit_q, ok_hit_d;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] d_out_d;
  logic [DATA_W-1:0] rdata_d;
  logic              nomem_d;
  logic              parity_d;
  logic              ar_p1_d;
  logic              tmo_clear_c;
  logic              tmo_enable_c;
  logic              tmo_expired_c;

  mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_sys   (clk_sys),
    .clr_      (clr_),
    .clear     (tmo_clear_c),
    .enable    (tmo_enable_c),
    .expired_c (tmo_expired_c)
  );

  // Next-state and next-value logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    dir_rd_d     = dir_rd_q;
    inc_d        = inc_q;
    ok_hit_d     = ok_hit_q;
    a_d          = a;
    d_out_d      = d_out;
    rdata_d      = rdata;
    nomem_d      = alarm_nomem;
    parity_d     = alarm_parity;
    ar_p1_d      = 1'b0;
    tmo_clear_c  = 1'b0;
    tmo_enable_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_start || wr_start) begin
          state_d     = ST_REQ;
          a_d         = {nb, ar};
          d_out_d     = at;
          dir_rd_d    = rd_start;  // read wins a simultaneous request
          inc_d       = inc;
          ok_hit_d    = 1'b0;
          tmo_clear_c = 1'b1;
        end
      end

      ST_REQ: begin
        tmo_enable_c = 1'b1;
        if (ok) begin
          state_d  = ST_RELEASE;
          ok_hit_d = 1'b1;
          if (dir_rd_q) begin
            rdata_d = d_in;
          end
          if (pe) begin
            parity_d = 1'b1;
          end
        end else if (en) begin
          state_d = ST_RELEASE;
          nomem_d = 1'b1;
        end else if (tmo_expired_c) begin
          // Nobody answered, so there is no handshake to wait out.
          state_d = ST_DONE;
          nomem_d = 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!ok && !en) begin
          state_d = ST_DONE;
          ar_p1_d = inc_q && ok_hit_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; bus strobes follow the next state.
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      state_q      <= ST_IDLE;
      dir_rd_q     <= 1'b0;
      inc_q        <= 1'b0;
      ok_hit_q     <= 1'b0;
      req          <= 1'b0;
      rd           <= 1'b0;
      wr           <= 1'b0;
      a            <= '0;
      d_out        <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ar_p1        <= 1'b0;
      alarm_nomem  <= 1'b0;
      alarm_parity <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_rd_q     <= dir_rd_d;
      inc_q        <= inc_d;
      ok_hit_q     <= ok_hit_d;
      req          <= (state_d == ST_REQ);
      rd           <= (state_d == ST_REQ) && dir_rd_d;
      wr           <= (state_d == ST_REQ) && !dir_rd_d;
      a            <= a_d;
      d_out        <= d_out_d;
      rdata        <= rdata_d;
      busy         <= (state_d != ST_IDLE);
      done         <= (state_d == ST_DONE);
      ar_p1        <= ar_p1_d;
      alarm_nomem  <= nomem_d;
      alarm_parity <= parity_d;
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for the memory access sequencer.
module tb_mem_seq;

  localparam logic [7:0] TB_TIMEOUT = 8'd10;

  logic        clk_sys = 1'b0;
  logic        clr_;
  logic [15:0] ar, at, d_in;
  logic [3:0]  nb;
  logic        rd_start, wr_start, inc, ok, en, pe;
  logic        req, rd, wr, busy, done, ar_p1, alarm_nomem, alarm_parity;
  logic [19:0] a;
  logic [15:0] d_out, rdata;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  int p1_cnt   = 0;
  int done_base, p1_base, n;

  mem_seq #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .clr_         (clr_),
    .ar           (ar),
    .at           (at),
    .nb           (nb),
    .rd_start     (rd_start),
    .wr_start     (wr_start),
    .inc          (inc),
    .ok           (ok),
    .en           (en),
    .pe           (pe),
    .d_in         (d_in),
    .req          (req),
    .rd           (rd),
    .wr           (wr),
    .a            (a),
    .d_out        (d_out),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .ar_p1        (ar_p1),
    .alarm_nomem  (alarm_nomem),
    .alarm_parity (alarm_parity)
  );

  always #5 clk_sys = ~clk_sys;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk_sys) begin
    if (done)  done_cnt = done_cnt + 1;
    if (ar_p1) p1_cnt   = p1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    clr_ = 1'b0;
    repeat (2) @(negedge clk_sys);
    clr_ = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic mark();
    done_base = done_cnt;
    p1_base   = p1_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_ = 1'b0; ar = '0; at = '0; nb = '0; d_in = '0;
    rd_start = 0; wr_start = 0; inc = 0; ok = 0; en = 0; pe = 0;
    repeat (3) @(negedge clk_sys);
    check("rst_strobes", {29'd0, req, rd, wr}, 32'd0);
    check("rst_status",  {28'd0, busy, done, ar_p1, alarm_nomem}, 32'd0);
    check("rst_parity",  {31'd0, alarm_parity}, 32'd0);
    check("rst_a",       {12'd0, a}, 32'd0);
    check("rst_data",    {d_out, rdata}, 32'd0);
    clr_ = 1'b1;
    @(negedge clk_sys);

    // Read with increment, ok after three REQ cycles.
    mark();
    ar = 16'h1234; nb = 4'h2; rd_start = 1; inc = 1;
    @(negedge clk_sys);
    rd_start = 0; inc = 0;
    check("rd_strobes", {29'd0, req, rd, wr}, 32'h6);
    check("rd_a",       {12'd0, a}, 32'h21234);
    check("rd_busy",    {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk_sys);
    check("rd_req_hold", {12'd0, req, rd, wr, 1'b0, a[15:0]}, {12'd0, 4'b1100, 16'h1234});
    ok = 1; d_in = 16'hbeef;
    @(negedge clk_sys);
    check("rd_release", {30'd0, req, done}, 32'd0);
    check("rd_rdata",   {16'd0, rdata}, 32'hbeef);
    ok = 0; d_in = '0;
    @(negedge clk_sys);
    check("rd_done", {30'd0, done, ar_p1}, 32'h3);
    @(negedge clk_sys);
    check("rd_idle", {30'd0, busy, done}, 32'd0);
    repeat (2) @(negedge clk_sys);
    check("rd_done_pulses", done_cnt - done_base, 1);
    check("rd_p1_pulses",   p1_cnt - p1_base, 1);

    // Write without increment, ok after one REQ cycle.
    mark();
    ar = 16'h0042; nb = 4'h1; at = 16'hcafe; wr_start = 1; inc = 0;
    @(negedge clk_sys);
    wr_start = 0; at = 16'h0000;
    check("wr_strobes", {29'd0, req, rd, wr}, 32'h5);
    check("wr_dout",    {16'd0, d_out}, 32'hcafe);
    check("wr_a",       {12'd0, a}, 32'h10042);
    ok = 1;
    @(negedge clk_sys);
    check("wr_release", {29'd0, req, rd, wr}, 32'd0);
    ok = 0;
    @(negedge clk_sys);
    check("wr_done", {30'd0, done, ar_p1}, 32'h2);
    repeat (3) @(negedge clk_sys);
    check("wr_pulses", {p1_cnt - p1_base, done_cnt - done_base}, {32'd0, 32'd1});
    check("wr_rdata_kept", {16'd0, rdata}, 32'hbeef);

    // Not present, then a normal access with the alarm still set.
    mark();
    wr_start = 1; inc = 1;
    @(negedge clk_sys);
    wr_start = 0; inc = 0; en = 1;
    @(negedge clk_sys);
    check("np_release", {29'd0, req, busy, alarm_nomem}, 32'h3);
    en = 0;
    @(negedge clk_sys);
    check("np_done", {30'd0, done, ar_p1}, 32'h2);
    @(negedge clk_sys);
    rd_start = 1; inc = 1;
    @(negedge clk_sys);
    rd_start = 0; inc = 0; ok = 1; d_in = 16'h0f0f;
    @(negedge clk_sys);
    ok = 0; d_in = '0;
    @(negedge clk_sys);
    check("np_next_done", {29'd0, done, ar_p1, alarm_nomem}, 32'h7);
    check("np_next_rdata", {16'd0, rdata}, 32'h0f0f);
    repeat (2) @(negedge clk_sys);
    check("np_p1_pulses", p1_cnt - p1_base, 1);

    // Alarms clear only on reset; then a no-answer timeout.
    do_reset();
    check("rst_clears_alarm", {31'd0, alarm_nomem}, 32'd0);
    mark();
    rd_start = 1; inc = 1;
    n = 0;
    for (int i = 0; i < 4 * TB_TIMEOUT; i++) begin
      @(negedge clk_sys);
      rd_start = 0; inc = 0;
      n = n + 1;
      if (done) break;
    end
    check("tmo_latency", n, TB_TIMEOUT + 1);
    check("tmo_alarm",   {30'd0, alarm_nomem, req}, 32'h2);
    repeat (2) @(negedge clk_sys);
    check("tmo_no_p1", p1_cnt - p1_base, 0);
    check("tmo_idle",  {31'd0, busy}, 32'd0);

    // Parity error on a read, ok held through the release phase, start ignored.
    do_reset();
    mark();
    rd_start = 1;
    @(negedge clk_sys);
    rd_start = 0; ok = 1; pe = 1; d_in = 16'h5a5a;
    @(negedge clk_sys);
    check("pe_release", {30'd0, req, done}, 32'd0);
    check("pe_rdata",   {16'd0, rdata}, 32'h5a5a);
    check("pe_alarm",   {30'd0, alarm_parity, alarm_nomem}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      wr_start = (i == 1);
      @(negedge clk_sys);
      check("hs_hold", {30'd0, busy, done}, 32'h2);
    end
    wr_start = 0; ok = 0; pe = 0; d_in = '0;
    @(negedge clk_sys);
    check("hs_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk_sys);
    check("hs_no_queue", {31'd0, busy}, 32'd0);
    check("hs_one_done", done_cnt - done_base, 1);

    // Asynchronous abort mid-access, then a clean write.
    ar = 16'h0001; nb = 4'h0; at = 16'h1357; rd_start = 1;
    @(negedge clk_sys);
    rd_start = 0;
    check("ab_in_req", {31'd0, req}, 32'd1);
    #2 clr_ = 1'b0;
    #1;
    check("ab_strobes", {28'd0, req, rd, wr, busy}, 32'd0);
    check("ab_regs", {12'd0, a}, 32'd0);
    check("ab_flags", {29'd0, done, ar_p1, alarm_parity}, 32'd0);
    @(negedge clk_sys);
    clr_ = 1'b1;
    @(negedge clk_sys);
    wr_start = 1;
    @(negedge clk_sys);
    wr_start = 0;
    check("ab_wr_strobes", {29'd0, req, rd, wr}, 32'h5);
    check("ab_wr_dout", {16'd0, d_out}, 32'h1357);
    ok = 1;
    @(negedge clk_sys);
    ok = 0;
    @(negedge clk_sys);
    check("ab_wr_done", {30'd0, done, alarm_nomem}, 32'h2);
    @(negedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
